agg_win: RTL and testbench

Parametrised multi-channel windowed aggregator for the NNA datapath. Accepts `num_ch` signed samples per beat over a valid/ready handshake and accumulates each channel over a configurable window of 1..2^`len_width` beats. At window end it presents the raw sum to the ALU alongside an activated, width-reduced result. Extends `agg` with channel count, window length, optional ReLU, saturation and backpressure.

---
 rtl/agg_win_if.sv | 29 ++
 rtl/agg_win.sv | 149 ++++++++++++++
 tb/tb_agg_win.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/agg_win_if.sv
// Handshake and result bus between the aggregator and its producer/consumer.
// The master side feeds beats and configuration and consumes results.
interface agg_win_if #(
  parameter int agg_width = 12,
  parameter int acc_width = 20,
  parameter int num_ch    = 4,
  parameter int len_width = 4
);
  logic [len_width-1:0]        cfg_len;
  logic                        cfg_relu;
  logic                        in_valid;
  logic                        in_ready;
  logic [num_ch*agg_width-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [num_ch*acc_width-1:0] agg_out2alu;
  logic [num_ch*agg_width-1:0] agg_out_acted;
  logic [num_ch-1:0]           out_ovf;

  modport master (
    output cfg_len, cfg_relu, in_valid, in_data, out_ready,
    input  in_ready, out_valid, agg_out2alu, agg_out_acted, out_ovf
  );

  modport slave (
    input  cfg_len, cfg_relu, in_valid, in_data, out_ready,
    output in_ready, out_valid, agg_out2alu, agg_out_acted, out_ovf
  );
endinterface

// File: rtl/agg_win.sv
// Multi-channel windowed aggregator: saturating per-channel sums over a
// configurable window, with raw and activated (optional ReLU) results.
module agg_win #(
  parameter int agg_width = 12,
  parameter int acc_width = 20,
  parameter int num_ch    = 4,
  parameter int len_width = 4
) (
  input logic       clk,
  input logic       rst,
  agg_win_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic signed [acc_width:0] ACC_MAX = {2'b00, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width:0] ACC_MIN = {2'b11, {(acc_width-1){1'b0}}};
  localparam logic signed [acc_width-1:0] AGG_MAX =
    {{(acc_width-agg_width+1){1'b0}}, {(agg_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] AGG_MIN =
    {{(acc_width-agg_width+1){1'b1}}, {(agg_width-1){1'b0}}};

  state_t state, state_next;
  logic [len_width-1:0]        cnt, cnt_next, len_q, len_next;
  logic                        relu_q, relu_next;
  logic [num_ch*acc_width-1:0] acc_q, acc_next;
  logic [num_ch*agg_width-1:0] acted_q, acted_next;
  logic [num_ch-1:0]           ovf_q, ovf_next;
  logic                        out_valid_q;
  logic                        take;

  // Returns {clamped, value}; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [acc_width:0] sat_add(
    input logic signed [acc_width-1:0] a,
    input logic signed [agg_width-1:0] b
  );
    logic signed [acc_width:0] s;
    s = (acc_width+1)'(a) + (acc_width+1)'(b);
    if (s > ACC_MAX)
      return {1'b1, ACC_MAX[acc_width-1:0]};
    else if (s < ACC_MIN)
      return {1'b1, ACC_MIN[acc_width-1:0]};
    else
      return {1'b0, s[acc_width-1:0]};
  endfunction

  function automatic logic [agg_width-1:0] activate(
    input logic signed [acc_width-1:0] x,
    input logic                        relu
  );
    logic signed [acc_width-1:0] y;
    y = x;
    if (relu && y < 0)
      y = '0;
    if (y > AGG_MAX)
      y = AGG_MAX;
    else if (y < AGG_MIN)
      y = AGG_MIN;
    return y[agg_width-1:0];
  endfunction

  assign bus.in_ready = rst && (state != HOLD);
  assign take         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    len_next   = len_q;
    relu_next  = relu_q;
    case (state)
      IDLE: begin
        if (take) begin
          cnt_next   = '0;
          len_next   = bus.cfg_len;
          relu_next  = bus.cfg_relu;
          state_next = (bus.cfg_len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (take) begin
          cnt_next = cnt + 1'b1;
          if (cnt_next == len_q)
            state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The activated result is computed from the next accumulator value so it
  // leaves a register alongside the raw sum, with the window's latched ReLU.
  always_comb begin
    logic signed [agg_width-1:0] sample;
    logic [acc_width:0]          sat_res;
    sample     = '0;
    sat_res    = '0;
    acc_next   = acc_q;
    ovf_next   = ovf_q;
    acted_next = acted_q;
    for (int c = 0; c < num_ch; c++) begin
      sample = bus.in_data[c*agg_width +: agg_width];
      if (take) begin
        if (state == IDLE) begin
          acc_next[c*acc_width +: acc_width] = acc_width'(sample);
          ovf_next[c] = 1'b0;
        end else begin
          sat_res = sat_add(acc_q[c*acc_width +: acc_width], sample);
          acc_next[c*acc_width +: acc_width] = sat_res[acc_width-1:0];
          if (sat_res[acc_width])
            ovf_next[c] = 1'b1;
        end
      end
      acted_next[c*agg_width +: agg_width] =
        activate(acc_next[c*acc_width +: acc_width], relu_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      len_q       <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      acted_q     <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      len_q       <= len_next;
      relu_q      <= relu_next;
      acc_q       <= acc_next;
      acted_q     <= acted_next;
      ovf_q       <= ovf_next;
      out_valid_q <= (state_next == HOLD);
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.agg_out2alu   = acc_q;
  assign bus.agg_out_acted = acted_q;
  assign bus.out_ovf       = ovf_q;

endmodule

// File: tb/tb_agg_win.sv
// Scoreboard bench for agg_win: a reference model pushes expected window
// results as beats are driven; each test pops and compares when out_valid rises.
module tb_agg_win;

  localparam int AGG_W = 12;
  localparam int ACC_W = 14;
  localparam int NCH   = 4;
  localparam int LW    = 4;
  localparam int ACC_HI = (1 << (ACC_W-1)) - 1;
  localparam int ACC_LO = -(1 << (ACC_W-1));
  localparam int AGG_HI = (1 << (AGG_W-1)) - 1;
  localparam int AGG_LO = -(1 << (AGG_W-1));

  typedef struct packed {
    logic [NCH*ACC_W-1:0] acc;
    logic [NCH*AGG_W-1:0] acted;
    logic [NCH-1:0]       ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  int   beat_val [16][NCH];

  agg_win_if #(.agg_width(AGG_W), .acc_width(ACC_W), .num_ch(NCH), .len_width(LW)) bus ();

  agg_win #(.agg_width(AGG_W), .acc_width(ACC_W), .num_ch(NCH), .len_width(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_beats();
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < NCH; c++)
        beat_val[i][c] = 0;
  endtask

  task automatic drive_beat(input logic [NCH*AGG_W-1:0] d, output logic ok);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Model the window, push its expected result, then drive its beats; the
  // config is scrambled after the first beat to show it is latched.
  task automatic send_window(input int len, input logic relu);
    exp_t e;
    logic [NCH*AGG_W-1:0] d;
    logic ok;
    int s, a;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      s = 0;
      for (int i = 0; i <= len; i++) begin
        s = (i == 0) ? beat_val[i][c] : s + beat_val[i][c];
        if (s > ACC_HI) begin s = ACC_HI; e.ovf[c] = 1'b1; end
        if (s < ACC_LO) begin s = ACC_LO; e.ovf[c] = 1'b1; end
      end
      a = (relu && s < 0) ? 0 : s;
      if (a > AGG_HI) a = AGG_HI;
      if (a < AGG_LO) a = AGG_LO;
      e.acc[c*ACC_W +: ACC_W]   = ACC_W'(s);
      e.acted[c*AGG_W +: AGG_W] = AGG_W'(a);
    end
    sb.push_back(e);
    bus.cfg_len  = LW'(len);
    bus.cfg_relu = relu;
    for (int i = 0; i <= len; i++) begin
      d = '0;
      for (int c = 0; c < NCH; c++)
        d[c*AGG_W +: AGG_W] = AGG_W'(beat_val[i][c]);
      drive_beat(d, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL beat_accept in_ready=%b required 1 (beat %0d)", ok, i);
      end
      if (i == 0) begin
        bus.cfg_len  = ~LW'(len);
        bus.cfg_relu = ~relu;
      end
    end
  endtask

  task automatic get_result(output logic got, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    got = bus.out_valid;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {NCH{12'h123}};
    bus.cfg_len  = '0;
    bus.cfg_relu = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got=%b required 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got=%b required 0", bus.out_valid);
    end
    checks++;
    if ({bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs acc=%h acted=%h ovf=%b required all 0",
               bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_state in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    logic got;
    int lat;
    clear_beats();
    beat_val[0][0] = 1;  beat_val[1][0] = 3;   beat_val[2][0] = 2;
    beat_val[0][1] = 10; beat_val[1][1] = -20; beat_val[2][1] = 30;
    send_window(2, 1'b0);
    get_result(got, lat);
    e = sb.pop_front();
    checks++;
    if (!got || lat != 0) begin
      errors++;
      $display("[TB] FAIL basic_latency out_valid=%b wait=%0d required 1 0", got, lat);
    end
    checks++;
    if ({bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
      errors++;
      $display("[TB] FAIL basic_result acc=%h acted=%h ovf=%b required acc=%h acted=%h ovf=%b",
               bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf, e.acc, e.acted, e.ovf);
    end
    checks++;
    if (bus.agg_out2alu[ACC_W-1:0] !== 14'd6 || bus.agg_out_acted[AGG_W-1:0] !== 12'd6) begin
      errors++;
      $display("[TB] FAIL basic_ch0 acc=%0d acted=%0d required 6 6",
               bus.agg_out2alu[ACC_W-1:0], bus.agg_out_acted[AGG_W-1:0]);
    end
    release_result();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_release in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_relu();
    exp_t e;
    logic got;
    int lat;
    logic [AGG_W-1:0] want;
    for (int r = 1; r >= 0; r--) begin
      clear_beats();
      beat_val[0][1] = -5; beat_val[1][1] = 2;
      beat_val[0][3] = -7; beat_val[1][3] = 900;
      send_window(1, r[0]);
      get_result(got, lat);
      e = sb.pop_front();
      want = (r == 1) ? 12'h000 : 12'hFFD;
      checks++;
      if (!got || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
        errors++;
        $display("[TB] FAIL relu_result relu=%0d valid=%b acc=%h acted=%h required acc=%h acted=%h",
                 r, got, bus.agg_out2alu, bus.agg_out_acted, e.acc, e.acted);
      end
      checks++;
      if (bus.agg_out_acted[AGG_W +: AGG_W] !== want) begin
        errors++;
        $display("[TB] FAIL relu_ch1 relu=%0d acted=%h required %h",
                 r, bus.agg_out_acted[AGG_W +: AGG_W], want);
      end
      release_result();
    end
  endtask

  task automatic test_act_sat();
    exp_t e;
    logic got;
    int lat;
    clear_beats();
    beat_val[0][0] = 1024;  beat_val[1][0] = 2047;
    beat_val[0][2] = -2048; beat_val[1][2] = -2048;
    send_window(1, 1'b0);
    get_result(got, lat);
    e = sb.pop_front();
    checks++;
    if (!got || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
      errors++;
      $display("[TB] FAIL act_sat_result valid=%b acc=%h acted=%h ovf=%b required acc=%h acted=%h ovf=%b",
               got, bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf, e.acc, e.acted, e.ovf);
    end
    checks++;
    if (bus.agg_out_acted[0 +: AGG_W] !== 12'h7FF || bus.agg_out_acted[2*AGG_W +: AGG_W] !== 12'h800
        || bus.agg_out2alu[2*ACC_W +: ACC_W] !== 14'h3000 || bus.out_ovf !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL act_sat_clamp ch0=%h ch2=%h ch2acc=%h ovf=%b required 7ff 800 3000 0000",
               bus.agg_out_acted[0 +: AGG_W], bus.agg_out_acted[2*AGG_W +: AGG_W],
               bus.agg_out2alu[2*ACC_W +: ACC_W], bus.out_ovf);
    end
    release_result();
  endtask

  task automatic test_acc_sat();
    exp_t e;
    logic got;
    int lat;
    clear_beats();
    for (int i = 0; i < 5; i++) begin
      beat_val[i][0] = 2047;
      beat_val[i][1] = i + 1;
    end
    send_window(4, 1'b1);
    get_result(got, lat);
    e = sb.pop_front();
    checks++;
    if (!got || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
      errors++;
      $display("[TB] FAIL acc_sat_result valid=%b acc=%h acted=%h ovf=%b required acc=%h acted=%h ovf=%b",
               got, bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf, e.acc, e.acted, e.ovf);
    end
    checks++;
    if (bus.agg_out2alu[0 +: ACC_W] !== 14'h1FFF || bus.out_ovf !== 4'b0001
        || bus.agg_out2alu[ACC_W +: ACC_W] !== 14'd15) begin
      errors++;
      $display("[TB] FAIL acc_sat_ch0 acc=%h ovf=%b ch1=%0d required 1fff 0001 15",
               bus.agg_out2alu[0 +: ACC_W], bus.out_ovf, bus.agg_out2alu[ACC_W +: ACC_W]);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic got;
    int lat;
    clear_beats();
    beat_val[0][3] = 100; beat_val[1][3] = -300;
    send_window(1, 1'b0);
    get_result(got, lat);
    e = sb.pop_front();
    bus.in_data  = {NCH{12'h055}};
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
          || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
        errors++;
        $display("[TB] FAIL hold_stable cycle=%0d valid=%b in_ready=%b acc=%h acted=%h required 1 0 acc=%h acted=%h",
                 k, bus.out_valid, bus.in_ready, bus.agg_out2alu, bus.agg_out_acted, e.acc, e.acted);
      end
    end
    release_result();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
    clear_beats();
    beat_val[0][0] = 7;
    send_window(0, 1'b0);
    get_result(got, lat);
    e = sb.pop_front();
    checks++;
    if (!got || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
      errors++;
      $display("[TB] FAIL after_hold_result valid=%b acc=%h acted=%h required acc=%h acted=%h",
               got, bus.agg_out2alu, bus.agg_out_acted, e.acc, e.acted);
    end
    release_result();
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic got, ok;
    int lat;
    bus.cfg_len  = LW'(3);
    bus.cfg_relu = 1'b0;
    for (int i = 0; i < 2; i++)
      drive_beat({NCH{12'd500}}, ok);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.agg_out2alu !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear valid=%b acc=%h required 0 0",
               bus.out_valid, bus.agg_out2alu);
    end
    rst = 1'b1;
    @(negedge clk);
    clear_beats();
    for (int i = 0; i < 4; i++) beat_val[i][0] = i + 1;
    send_window(3, 1'b0);
    get_result(got, lat);
    e = sb.pop_front();
    checks++;
    if (!got || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
      errors++;
      $display("[TB] FAIL mid_reset_result valid=%b acc=%h acted=%h required acc=%h acted=%h",
               got, bus.agg_out2alu, bus.agg_out_acted, e.acc, e.acted);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic got;
    int lat, len;
    for (int w = 0; w < 8; w++) begin
      clear_beats();
      len = int'($urandom_range(6));
      for (int i = 0; i <= len; i++)
        for (int c = 0; c < NCH; c++)
          beat_val[i][c] = int'($urandom_range(4095)) - 2048;
      send_window(len, 1'($urandom_range(1)));
      get_result(got, lat);
      e = sb.pop_front();
      checks++;
      if (!got || lat != 0
          || {bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf} !== {e.acc, e.acted, e.ovf}) begin
        errors++;
        $display("[TB] FAIL b2b_result win=%0d valid=%b wait=%0d acc=%h acted=%h ovf=%b required acc=%h acted=%h ovf=%b",
                 w, got, lat, bus.agg_out2alu, bus.agg_out_acted, bus.out_ovf, e.acc, e.acted, e.ovf);
      end
      release_result();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_len   = '0;
    bus.cfg_relu  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_relu();
    test_act_sat();
    test_acc_sat();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
